// File: rtl/e10_obs_decoder.sv
// e10_obs_decoder: receive-side decoder for the 19-state e10 controller.
// Samples the 13-bit output word on obs_valid, reconstructs the destination
// state index, flags words no legal transition produces, and keeps a
// saturating error counter with a sticky alarm.
// Optional feature: define E10_SUCC_CHECK_EN to also check every decoded
// destination against the successor set of the tracked state.
module e10_obs_decoder #(
    parameter int ERR_W        = 4,
    parameter int ALARM_THRESH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             obs_valid,
    input  logic [12:0]      y_in,
    input  logic             sync_s1,
    input  logic             err_clr,
    output logic [4:0]       state_idx,
    output logic             state_upd,
    output logic             code_err,
    output logic             succ_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             alarm
);

    localparam logic [ERR_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] THRESH  = ERR_W'(ALARM_THRESH);

    // Exact-match decode of a nonzero output word; 0 means no legal transition emits it.
    function automatic logic [4:0] code_dst(input logic [12:0] y);
        case (y)
            13'h1100: code_dst = 5'd2;
            13'h0003: code_dst = 5'd3;
            13'h0110: code_dst = 5'd4;
            13'h0017: code_dst = 5'd5;
            13'h0440: code_dst = 5'd6;
            13'h0170: code_dst = 5'd7;
            13'h0140: code_dst = 5'd8;
            13'h0001: code_dst = 5'd9;
            13'h000D: code_dst = 5'd10;
            13'h0002: code_dst = 5'd11;
            13'h1010: code_dst = 5'd12;
            13'h1000: code_dst = 5'd13;
            13'h1030: code_dst = 5'd14;
            13'h0A00: code_dst = 5'd15;
            13'h0088: code_dst = 5'd16;
            13'h1440: code_dst = 5'd17;
            13'h0200: code_dst = 5'd18;
            default:  code_dst = 5'd0;
        endcase
    endfunction

    // The all-zero word is only legal from a few states, so its meaning depends on where we are.
    function automatic logic [4:0] zero_dst(input logic [4:0] cur);
        case (cur)
            5'd4, 5'd11, 5'd18: zero_dst = 5'd1;
            5'd15:              zero_dst = 5'd15;
            default:            zero_dst = 5'd0;
        endcase
    endfunction

    // Saturating increment: the counter pins at all-ones rather than wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        sat_inc = (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

`ifdef E10_SUCC_CHECK_EN
    // Successor sets of the controller graph.
    function automatic logic succ_ok(input logic [4:0] cur, input logic [4:0] dst);
        case (cur)
            5'd1:    succ_ok = dst inside {5'd2, 5'd3, 5'd4, 5'd5};
            5'd2:    succ_ok = dst inside {5'd4, 5'd6, 5'd7, 5'd8, 5'd9};
            5'd3:    succ_ok = dst inside {5'd6, 5'd10, 5'd11, 5'd12};
            5'd4:    succ_ok = dst inside {5'd1, 5'd6, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
            5'd5:    succ_ok = dst inside {5'd6, 5'd8, 5'd12};
            5'd6:    succ_ok = dst inside {5'd2, 5'd7, 5'd8, 5'd9, 5'd14};
            5'd7:    succ_ok = dst inside {5'd7, 5'd8, 5'd9};
            5'd8:    succ_ok = dst inside {5'd15, 5'd16, 5'd17};
            5'd9:    succ_ok = dst inside {5'd8, 5'd13};
            5'd10:   succ_ok = dst inside {5'd5, 5'd7, 5'd8, 5'd9};
            5'd11:   succ_ok = dst inside {5'd1, 5'd4, 5'd8, 5'd18};
            5'd12:   succ_ok = dst inside {5'd15, 5'd16, 5'd17};
            5'd13:   succ_ok = dst inside {5'd4, 5'd11, 5'd19};
            5'd14:   succ_ok = dst inside {5'd11, 5'd15, 5'd18};
            5'd15:   succ_ok = dst inside {5'd10, 5'd15, 5'd17};
            5'd16:   succ_ok = dst inside {5'd7, 5'd8, 5'd9};
            5'd17:   succ_ok = dst inside {5'd5, 5'd7, 5'd10, 5'd14, 5'd15};
            5'd18:   succ_ok = dst inside {5'd1, 5'd4, 5'd8, 5'd18};
            5'd19:   succ_ok = dst inside {5'd4, 5'd8, 5'd18};
            default: succ_ok = 1'b0;
        endcase
    endfunction
`endif

    logic             word_zero_p0;
    logic [4:0]       dst_p0;
    logic             take_p0;
    logic             legal_p0;
    logic             code_err_p0;
    logic             succ_err_p0;
    logic             err_p0;
    logic [ERR_W-1:0] cnt_p0;
    logic             alarm_p0;

    // Decode the sampled word against the tracked state and form the next counter/alarm values.
    always_comb begin
        word_zero_p0 = (y_in == 13'd0);
        dst_p0       = word_zero_p0 ? zero_dst(state_idx) : code_dst(y_in);
        take_p0      = obs_valid & ~sync_s1;
        legal_p0     = (dst_p0 != 5'd0);
        code_err_p0  = take_p0 & ~legal_p0;
`ifdef E10_SUCC_CHECK_EN
        // Zero-word destinations are successor-consistent by construction.
        succ_err_p0  = take_p0 & legal_p0 & ~word_zero_p0 & ~succ_ok(state_idx, dst_p0);
`else
        succ_err_p0  = 1'b0;
`endif
        err_p0       = code_err_p0 | succ_err_p0;
        if (err_clr)
            cnt_p0 = err_p0 ? {{(ERR_W-1){1'b0}}, 1'b1} : '0;
        else if (err_p0)
            cnt_p0 = sat_inc(err_cnt);
        else
            cnt_p0 = err_cnt;
        alarm_p0     = ((err_clr ? 1'b0 : alarm) | (cnt_p0 >= THRESH));
    end

    // ---- stage p0 -> registered outputs ----
    // Tracked state and pulses; resync wins over a same-cycle sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_idx <= 5'd1;
            state_upd <= 1'b0;
            code_err  <= 1'b0;
            succ_err  <= 1'b0;
            err_cnt   <= '0;
            alarm     <= 1'b0;
        end else begin
            if (sync_s1)
                state_idx <= 5'd1;
            else if (take_p0 && legal_p0)
                state_idx <= dst_p0;
            state_upd <= take_p0 & legal_p0;
            code_err  <= code_err_p0;
            succ_err  <= succ_err_p0;
            err_cnt   <= cnt_p0;
            alarm     <= alarm_p0;
        end
    end

endmodule

// File: tb/tb_e10_obs_decoder.sv
// Directed testbench for e10_obs_decoder (ERR_W=4, ALARM_THRESH=3).
module tb_e10_obs_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        obs_valid = 1'b0;
    logic [12:0] y_in = 13'd0;
    logic        sync_s1 = 1'b0;
    logic        err_clr = 1'b0;
    logic [4:0]  state_idx;
    logic        state_upd;
    logic        code_err;
    logic        succ_err;
    logic [3:0]  err_cnt;
    logic        alarm;

    int checks = 0;
    int failures = 0;

`ifdef E10_SUCC_CHECK_EN
    localparam logic SUCC_ON = 1'b1;
`else
    localparam logic SUCC_ON = 1'b0;
`endif

    e10_obs_decoder #(.ERR_W(4), .ALARM_THRESH(3)) dut (
        .clk(clk), .rst(rst), .obs_valid(obs_valid), .y_in(y_in),
        .sync_s1(sync_s1), .err_clr(err_clr), .state_idx(state_idx),
        .state_upd(state_upd), .code_err(code_err), .succ_err(succ_err),
        .err_cnt(err_cnt), .alarm(alarm)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge pass, sample 1 time unit later.
    task automatic apply(input logic v, input logic [12:0] y, input logic s, input logic c);
        obs_valid = v; y_in = y; sync_s1 = s; err_clr = c;
        @(posedge clk); #1;
        obs_valid = 1'b0; y_in = 13'd0; sync_s1 = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state_idx !== 5'd1) begin failures++; $display("FAIL reset_state got=%0d exp=1", state_idx); end
        checks++; if (state_upd !== 1'b0) begin failures++; $display("FAIL reset_upd got=%0b exp=0", state_upd); end
        checks++; if (code_err !== 1'b0) begin failures++; $display("FAIL reset_code_err got=%0b exp=0", code_err); end
        checks++; if (succ_err !== 1'b0) begin failures++; $display("FAIL reset_succ_err got=%0b exp=0", succ_err); end
        checks++; if (err_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", err_cnt); end
        checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL reset_alarm got=%0b exp=0", alarm); end
    endtask

    task automatic test_legal();
        apply(1'b1, 13'h0003, 1'b0, 1'b0);
        checks++; if (state_idx !== 5'd3) begin failures++; $display("FAIL legal_state got=%0d exp=3", state_idx); end
        checks++; if (state_upd !== 1'b1) begin failures++; $display("FAIL legal_upd got=%0b exp=1", state_upd); end
        checks++; if (code_err !== 1'b0) begin failures++; $display("FAIL legal_code_err got=%0b exp=0", code_err); end
        checks++; if (err_cnt !== 4'd0) begin failures++; $display("FAIL legal_cnt got=%0d exp=0", err_cnt); end
        apply(1'b0, 13'h0000, 1'b0, 1'b0);
        checks++; if (state_upd !== 1'b0) begin failures++; $display("FAIL legal_upd_pulse got=%0b exp=0", state_upd); end
    endtask

    task automatic test_zero_word();
        apply(1'b0, 13'h0, 1'b1, 1'b0);
        apply(1'b1, 13'h0110, 1'b0, 1'b0);
        checks++; if (state_idx !== 5'd4) begin failures++; $display("FAIL zero_to_s4 got=%0d exp=4", state_idx); end
        apply(1'b1, 13'h0000, 1'b0, 1'b0);
        checks++; if (state_idx !== 5'd1) begin failures++; $display("FAIL zero_s4 got=%0d exp=1", state_idx); end
        checks++; if (code_err !== 1'b0) begin failures++; $display("FAIL zero_s4_err got=%0b exp=0", code_err); end
        apply(1'b1, 13'h0110, 1'b0, 1'b0);
        apply(1'b1, 13'h1010, 1'b0, 1'b0);
        apply(1'b1, 13'h0A00, 1'b0, 1'b0);
        checks++; if (state_idx !== 5'd15) begin failures++; $display("FAIL zero_to_s15 got=%0d exp=15", state_idx); end
        apply(1'b1, 13'h0000, 1'b0, 1'b0);
        checks++; if (state_idx !== 5'd15) begin failures++; $display("FAIL zero_s15 got=%0d exp=15", state_idx); end
        checks++; if (code_err !== 1'b0) begin failures++; $display("FAIL zero_s15_err got=%0b exp=0", code_err); end
        checks++; if (state_upd !== 1'b1) begin failures++; $display("FAIL zero_s15_upd got=%0b exp=1", state_upd); end
    endtask

    task automatic test_alarm();
        logic [3:0] exp_cnt;
        apply(1'b0, 13'h0, 1'b1, 1'b0);
        apply(1'b1, 13'h0003, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            apply(1'b1, 13'h0000, 1'b0, 1'b0);
            exp_cnt = 4'(i);
            checks++; if (code_err !== 1'b1) begin failures++; $display("FAIL alarm_code_err[%0d] got=%0b exp=1", i, code_err); end
            checks++; if (err_cnt !== exp_cnt) begin failures++; $display("FAIL alarm_cnt[%0d] got=%0d exp=%0d", i, err_cnt, exp_cnt); end
            checks++; if (alarm !== (i >= 3)) begin failures++; $display("FAIL alarm_flag[%0d] got=%0b exp=%0b", i, alarm, (i >= 3)); end
        end
        checks++; if (state_idx !== 5'd3) begin failures++; $display("FAIL alarm_state got=%0d exp=3", state_idx); end
        checks++; if (state_upd !== 1'b0) begin failures++; $display("FAIL alarm_upd got=%0b exp=0", state_upd); end
        apply(1'b0, 13'h0, 1'b0, 1'b0);
        checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL alarm_sticky got=%0b exp=1", alarm); end
        apply(1'b0, 13'h0, 1'b0, 1'b1);
        checks++; if (err_cnt !== 4'd0) begin failures++; $display("FAIL clr_cnt got=%0d exp=0", err_cnt); end
        checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL clr_alarm got=%0b exp=0", alarm); end
    endtask

    task automatic test_saturate();
        apply(1'b1, 13'h0007, 1'b0, 1'b0);
        checks++; if (code_err !== 1'b1) begin failures++; $display("FAIL unlisted_err got=%0b exp=1", code_err); end
        checks++; if (state_idx !== 5'd3) begin failures++; $display("FAIL unlisted_state got=%0d exp=3", state_idx); end
        checks++; if (err_cnt !== 4'd1) begin failures++; $display("FAIL unlisted_cnt got=%0d exp=1", err_cnt); end
        for (int i = 0; i < 19; i++) apply(1'b1, 13'h0007, 1'b0, 1'b0);
        checks++; if (err_cnt !== 4'd15) begin failures++; $display("FAIL sat_cnt got=%0d exp=15", err_cnt); end
        checks++; if (code_err !== 1'b1) begin failures++; $display("FAIL sat_err got=%0b exp=1", code_err); end
        checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL sat_alarm got=%0b exp=1", alarm); end
        apply(1'b1, 13'h0007, 1'b0, 1'b1);
        checks++; if (err_cnt !== 4'd1) begin failures++; $display("FAIL clr_err_cnt got=%0d exp=1", err_cnt); end
        checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL clr_err_alarm got=%0b exp=0", alarm); end
        apply(1'b0, 13'h0, 1'b0, 1'b1);
        checks++; if (err_cnt !== 4'd0) begin failures++; $display("FAIL clr2_cnt got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_sync_priority();
        apply(1'b1, 13'h0440, 1'b1, 1'b0);
        checks++; if (state_idx !== 5'd1) begin failures++; $display("FAIL sync_state got=%0d exp=1", state_idx); end
        checks++; if (state_upd !== 1'b0) begin failures++; $display("FAIL sync_upd got=%0b exp=0", state_upd); end
        checks++; if (code_err !== 1'b0) begin failures++; $display("FAIL sync_err got=%0b exp=0", code_err); end
    endtask

    task automatic test_idle();
        apply(1'b0, 13'h1FFF, 1'b0, 1'b0);
        checks++; if (state_idx !== 5'd1) begin failures++; $display("FAIL idle_state got=%0d exp=1", state_idx); end
        checks++; if (state_upd !== 1'b0) begin failures++; $display("FAIL idle_upd got=%0b exp=0", state_upd); end
        checks++; if (code_err !== 1'b0) begin failures++; $display("FAIL idle_err got=%0b exp=0", code_err); end
    endtask

    task automatic test_succ();
        apply(1'b0, 13'h0, 1'b1, 1'b1);
        apply(1'b1, 13'h0200, 1'b0, 1'b0);
        checks++; if (state_idx !== 5'd18) begin failures++; $display("FAIL succ_state got=%0d exp=18", state_idx); end
        checks++; if (succ_err !== SUCC_ON) begin failures++; $display("FAIL succ_err got=%0b exp=%0b", succ_err, SUCC_ON); end
        checks++; if (code_err !== 1'b0) begin failures++; $display("FAIL succ_code_err got=%0b exp=0", code_err); end
        checks++; if (err_cnt !== {3'b000, SUCC_ON}) begin failures++; $display("FAIL succ_cnt got=%0d exp=%0d", err_cnt, SUCC_ON); end
        checks++; if (state_upd !== 1'b1) begin failures++; $display("FAIL succ_upd got=%0b exp=1", state_upd); end
    endtask

    task automatic test_midstream_rst();
        apply(1'b0, 13'h0, 1'b1, 1'b0);
        apply(1'b1, 13'h0110, 1'b0, 1'b0);
        apply(1'b1, 13'h0007, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (state_idx !== 5'd1) begin failures++; $display("FAIL rst_async_state got=%0d exp=1", state_idx); end
        checks++; if (err_cnt !== 4'd0) begin failures++; $display("FAIL rst_async_cnt got=%0d exp=0", err_cnt); end
        @(posedge clk); #1;
        rst = 1'b0;
        apply(1'b1, 13'h0000, 1'b0, 1'b0);
        checks++; if (code_err !== 1'b1) begin failures++; $display("FAIL rst_zero_err got=%0b exp=1", code_err); end
        checks++; if (state_idx !== 5'd1) begin failures++; $display("FAIL rst_zero_state got=%0d exp=1", state_idx); end
    endtask

    initial begin
        test_reset();
        test_legal();
        test_zero_word();
        test_alarm();
        test_saturate();
        test_sync_priority();
        test_idle();
        test_succ();
        test_midstream_rst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
